// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl: sequences weight load, activation load, execute and psum write-back
// over every kernel position of a 3x3 convolution pass.
module conv_seq_ctrl #(
   parameter int col     = 8,
   parameter int row     = 8,
   parameter int len_nij = 36,
   parameter int nij_sz  = 6,
   parameter int len_kij = 9,
   parameter int htiles  = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        abort,
   output logic [33:0] inst,
   output logic        core_rst,
   output logic        mode,
   output logic        sel,
   output logic        relu,
   output logic [1:0]  tile,
   output logic        busy,
   output logic        done,
   output logic [3:0]  kij
);
   localparam logic [33:0] IDLE_W = 34'h1_800C_0000;
   typedef enum logic [3:0] {
      IDLE, CRST, CWAIT, KPRE, KLD, KGAP, AL0, AGAP, EXEC, EGAP, OPRE, OWR, OCLS, DRAIN, DONE
   } st_e;
   st_e         st_q, st_d;
   logic [15:0] t_q, t_d, len;
   logic [3:0]  j_q, j_d, kij_q, kij_d;
   logic [33:0] inst_q, inst_d;
   logic [1:0]  tile_q, tile_d;
   logic        core_rst_q, core_rst_d, mode_q, mode_d, sel_q, sel_d, relu_q, relu_d;
   logic        busy_q, busy_d, done_q, done_d;
   logic [10:0] wb, pb, a_x, a_p;
   logic        fin, kpre, kld, kgap, al0, agap, exe, opre, owr, l0_wr;
   always_comb begin
      len = (st_q == CWAIT || st_q == DRAIN) ? 16'd2 :
            (st_q == KLD) ? 16'(row + 2 * col) :
            (st_q == AL0 || st_q == OWR) ? 16'(len_nij) :
            (st_q == EXEC) ? 16'(len_nij + 2 * col) : 16'd1;
      fin = t_q == len - 16'd1;
      st_d = st_q;
      t_d = fin ? 16'd0 : t_q + 16'd1;
      j_d = j_q;
      kij_d = kij_q;
      if (st_q == IDLE) begin
         st_d = (start && !abort) ? CRST : IDLE;
         j_d = 4'd0;
         kij_d = 4'd0;
      end else if (fin) begin
         if (st_q == KGAP && j_q != 4'(htiles - 1)) begin
            st_d = KPRE;
            j_d = j_q + 4'd1;
         end else if (st_q == DRAIN && kij_q != 4'(len_kij - 1)) begin
            st_d = CRST;
            kij_d = kij_q + 4'd1;
            j_d = 4'd0;
         end else begin
            st_d = (st_q == DONE) ? IDLE : st_e'(st_q + 4'd1);
         end
      end
      if (abort && st_q != IDLE) begin
         st_d = IDLE;
         t_d = 16'd0;
         j_d = 4'd0;
         kij_d = 4'd0;
      end
      // outputs are derived from the next state so they line up with it once registered
      kpre = st_d == KPRE;
      kld = st_d == KLD;
      kgap = st_d == KGAP;
      al0 = st_d == AL0;
      agap = st_d == AGAP;
      exe = st_d == EXEC;
      opre = st_d == OPRE;
      owr = st_d == OWR;
      wb = 11'(32'h400 + (32'(kij_d) * htiles + 32'(j_d)) * 2 * col);
      pb = 11'(32'd0 - (32'(kij_d) % 3 + (32'(kij_d) / 3) * nij_sz));
      l0_wr = kpre || (kld && t_d < 16'(2 * col - 1)) || al0;
      a_x = kpre ? wb : kld ? wb + 11'(t_d) + 11'd1 : al0 ? 11'(t_d) : 11'd0;
      a_p = opre ? pb : owr ? pb + 11'(t_d) : 11'd0;
      inst_d = {(opre || owr) && kij_d != 4'd0, !owr, !owr, a_p, !l0_wr, 1'b1, a_x,
                opre || owr, 2'b00, kld || exe, l0_wr,
                exe && t_d < 16'(len_nij), kld && t_d < 16'(2 * col)};
      core_rst_d = st_d == CRST || (abort && st_q != IDLE);
      mode_d = 1'b0;
      tile_d = (kpre || kld || kgap) ? 2'(2'b01 << j_d) : (al0 || agap || exe) ? 2'b11 : 2'b01;
      sel_d = opre ? kij_d[0] : sel_q;
      relu_d = (st_d == IDLE || st_d == DONE) ? 1'b0 : opre ? kij_d == 4'(len_kij - 1) : relu_q;
      busy_d = st_d != IDLE && st_d != DONE;
      done_d = st_d == DONE;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st_q <= IDLE;
         t_q <= 16'd0;
         j_q <= 4'd0;
         kij_q <= 4'd0;
         inst_q <= IDLE_W;
         core_rst_q <= 1'b0;
         mode_q <= 1'b0;
         sel_q <= 1'b0;
         relu_q <= 1'b0;
         tile_q <= 2'b01;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         st_q <= st_d;
         t_q <= t_d;
         j_q <= j_d;
         kij_q <= kij_d;
         inst_q <= inst_d;
         core_rst_q <= core_rst_d;
         mode_q <= mode_d;
         sel_q <= sel_d;
         relu_q <= relu_d;
         tile_q <= tile_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end
   assign inst = inst_q;
   assign core_rst = core_rst_q;
   assign mode = mode_q;
   assign sel = sel_q;
   assign relu = relu_q;
   assign tile = tile_q;
   assign busy = busy_q;
   assign done = done_q;
   assign kij = kij_q;
endmodule

// File: tb/tb_conv_seq_ctrl.sv
// tb_conv_seq_ctrl: directed checks of a full pass, abort, start/abort priority and async reset.
module tb_conv_seq_ctrl;
   localparam logic [33:0] IDLE_W = 34'h1_800C_0000;
   logic        clk = 1'b0, reset, start, abort;
   logic [33:0] inst;
   logic        core_rst, mode, sel, relu, busy, done;
   logic [1:0]  tile;
   logic [3:0]  kij;
   int          checks = 0, errors = 0;
   int          n, done_n, busy_gap, ff_bad, ld, wr, ex, rd, done_cnt;
   conv_seq_ctrl dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .inst(inst),
      .core_rst(core_rst), .mode(mode), .sel(sel), .relu(relu), .tile(tile),
      .busy(busy), .done(done), .kij(kij)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [33:0] got, input logic [33:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   initial begin
      reset = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      repeat (2) step();
      check("rst_inst", inst, IDLE_W);
      check("rst_busy", busy, 0);
      check("rst_core_rst", core_rst, 0);
      check("rst_tile", tile, 2'b01);
      check("rst_kij", kij, 0);
      check("rst_done", done, 0);
      check("rst_mode", mode, 0);
      reset = 1'b0;
      step();
      start = 1'b1;
      step();
      start = 1'b0;
      check("crst_core_rst", core_rst, 1);
      check("crst_busy", busy, 1);
      check("crst_kij", kij, 0);
      n = 0;
      done_n = -1;
      busy_gap = 0;
      ff_bad = 0;
      ld = 0;
      wr = 0;
      ex = 0;
      rd = 0;
      while (n < 2000) begin
         if (done) begin
            done_n = n;
            break;
         end
         if (!busy) busy_gap++;
         if (inst[5:4] != 2'b00) ff_bad++;
         if (n >= 29 && n <= 54) begin
            ld += int'(inst[0]);
            wr += int'(inst[2]);
         end
         if (n >= 92 && n <= 143) begin
            ex += int'(inst[1]);
            rd += int'(inst[3]);
         end
         if (n == 1) check("cwait_core_rst", core_rst, 0);
         if (n == 29) begin
            check("kpre_j1_axmem", 34'(inst[17:7]), 34'h410);
            check("kpre_j1_tile", tile, 2'b10);
            check("kpre_j1_cenx", inst[19], 0);
         end
         if (n == 92) check("exec_tile", tile, 2'b11);
         if (n == 145) begin
            check("opre0_acc", inst[33], 0);
            check("opre0_apmem", 34'(inst[30:20]), 34'h000);
            check("opre0_ofifo", inst[6], 1);
         end
         if (n == 330) begin
            check("opre1_sel", sel, 1);
            check("opre1_apmem", 34'(inst[30:20]), 34'h7FF);
         end
         if (n == 885) begin
            check("opre4_apmem", 34'(inst[30:20]), 34'h7F9);
            check("opre4_acc", inst[33], 1);
            check("opre4_sel", sel, 0);
            check("opre4_kij", kij, 4);
         end
         if (n == 921) begin
            check("owr4_last_apmem", 34'(inst[30:20]), 34'h01C);
            check("owr4_cenp", inst[32], 0);
         end
         if (n == 1625) begin
            check("opre8_relu", relu, 1);
            check("opre8_apmem", 34'(inst[30:20]), 34'h7F2);
         end
         start = (n == 500);
         step();
         n++;
      end
      start = 1'b0;
      check("done_cycle", 34'(done_n), 34'd1665);
      check("busy_gaps", 34'(busy_gap), 0);
      check("fifo_bits_zero", 34'(ff_bad), 0);
      check("load_cnt", 34'(ld), 16);
      check("l0_wr_cnt", 34'(wr), 16);
      check("execute_cnt", 34'(ex), 36);
      check("l0_rd_cnt", 34'(rd), 52);
      check("done_busy", busy, 0);
      step();
      check("post_done", done, 0);
      check("post_relu", relu, 0);
      check("post_inst", inst, IDLE_W);
      // abort during EXEC at kij 3
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 652; i++) step();
      check("pre_abort_exec", inst[1], 1);
      check("pre_abort_kij", kij, 3);
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("abort_inst", inst, IDLE_W);
      check("abort_busy", busy, 0);
      check("abort_core_rst", core_rst, 1);
      check("abort_tile", tile, 2'b01);
      done_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         done_cnt += int'(done);
      end
      check("abort_no_done", 34'(done_cnt), 0);
      check("abort_core_rst_end", core_rst, 0);
      start = 1'b1;
      abort = 1'b1;
      step();
      start = 1'b0;
      abort = 1'b0;
      check("start_abort_busy", busy, 0);
      check("start_abort_crst", core_rst, 0);
      start = 1'b1;
      step();
      start = 1'b0;
      check("restart_kij", kij, 0);
      check("restart_core_rst", core_rst, 1);
      // async reset in the middle of OWR at kij 1
      for (int i = 0; i < 341; i++) step();
      check("owr1_apmem", 34'(inst[30:20]), 34'h7FF + 34'd10 - 34'h800);
      check("owr1_sel", sel, 1);
      check("owr1_kij", kij, 1);
      #2 reset = 1'b1;
      #1;
      check("async_inst", inst, IDLE_W);
      check("async_busy", busy, 0);
      check("async_kij", kij, 0);
      check("async_sel", sel, 0);
      check("async_tile", tile, 2'b01);
      step();
      reset = 1'b0;
      step();
      check("after_rst_done", done, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
